// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Conditions one raw mechanical push-button. The raw level is
//               passed through a two-flop synchroniser, debounced by a
//               four-state FSM, and turned into one-cycle press/release
//               pulses plus a hold-to-repeat step pulse for the duty register.
// Ports       : CLK          - system clock, rising edge
//               RST_N        - asynchronous active-low reset
//               switch_input - raw, asynchronous, bouncy level (1 = pressed)
//               level        - debounced button state
//               trans_up     - one-cycle pulse on an accepted 0->1 change
//               trans_dn     - one-cycle pulse on an accepted 1->0 change
//               step         - one-cycle pulse on every press and repeat tick
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,   // >= 1
    parameter int REPEAT_DELAY    = 25000000, // 0 disables auto-repeat
    parameter int REPEAT_PERIOD   = 5000000   // >= 1
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic switch_input,
    output logic level,
    output logic trans_up,
    output logic trans_dn,
    output logic step
);

    localparam int c_db_w    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_rep_max = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_rep_w   = $clog2(c_rep_max + 1);

    localparam logic [c_db_w-1:0]  c_db_limit = c_db_w'(DEBOUNCE_CYCLES);
    localparam logic [c_db_w-1:0]  c_db_one   = c_db_w'(1);
    localparam logic [c_rep_w-1:0] c_delay    = c_rep_w'(REPEAT_DELAY);
    localparam logic [c_rep_w-1:0] c_period   = c_rep_w'(REPEAT_PERIOD);
    localparam logic [c_rep_w-1:0] c_rep_one  = c_rep_w'(1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic               s1_q, s1_d;
    logic               s2_q, s2_d;
    state_t             state_q, state_d;
    logic [c_db_w-1:0]  db_cnt_q, db_cnt_d;
    logic [c_rep_w-1:0] rep_cnt_q, rep_cnt_d;
    logic               rep_started_q, rep_started_d; // first repeat tick already issued
    logic               level_q, level_d;
    logic               trans_up_q, trans_up_d;
    logic               trans_dn_q, trans_dn_d;
    logic               step_q, step_d;
    logic [c_rep_w-1:0] w_rep_next;

    always_comb begin
        s1_d          = switch_input;
        s2_d          = s1_q;
        state_d       = state_q;
        db_cnt_d      = db_cnt_q;
        rep_cnt_d     = rep_cnt_q;
        rep_started_d = rep_started_q;
        trans_up_d    = 1'b0;
        trans_dn_d    = 1'b0;
        step_d        = 1'b0;
        // rep_cnt_q never exceeds c_rep_max-1, so the increment cannot overflow
        w_rep_next    = rep_cnt_q + c_rep_one;

        case (state_q)
            IDLE: begin
                if (s2_q) begin
                    state_d  = PRESS_WAIT;
                    db_cnt_d = c_db_one;
                end
            end
            PRESS_WAIT: begin
                if (!s2_q) begin
                    state_d  = IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q == c_db_limit) begin
                    // Fresh press: repeat schedule restarts from zero
                    state_d       = HELD;
                    db_cnt_d      = '0;
                    trans_up_d    = 1'b1;
                    step_d        = 1'b1;
                    rep_cnt_d     = '0;
                    rep_started_d = 1'b0;
                end else begin
                    // Only reached below the limit, so the counter saturates
                    db_cnt_d = db_cnt_q + c_db_one;
                end
            end
            HELD: begin
                if (!s2_q) begin
                    // Repeat count is frozen while a release is being qualified
                    state_d  = RELEASE_WAIT;
                    db_cnt_d = c_db_one;
                end else if (REPEAT_DELAY != 0) begin
                    if (!rep_started_q) begin
                        if (w_rep_next == c_delay) begin
                            step_d        = 1'b1;
                            rep_cnt_d     = '0;
                            rep_started_d = 1'b1;
                        end else begin
                            rep_cnt_d = w_rep_next;
                        end
                    end else begin
                        if (w_rep_next == c_period) begin
                            step_d    = 1'b1;
                            rep_cnt_d = '0;
                        end else begin
                            rep_cnt_d = w_rep_next;
                        end
                    end
                end
            end
            RELEASE_WAIT: begin
                if (s2_q) begin
                    // Rejected release bounce: resume the frozen repeat count
                    state_d  = HELD;
                    db_cnt_d = '0;
                end else if (db_cnt_q == c_db_limit) begin
                    state_d    = IDLE;
                    db_cnt_d   = '0;
                    trans_dn_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + c_db_one;
                end
            end
            default: begin
                state_d  = IDLE;
                db_cnt_d = '0;
            end
        endcase

        level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            state_q       <= IDLE;
            db_cnt_q      <= '0;
            rep_cnt_q     <= '0;
            rep_started_q <= 1'b0;
            level_q       <= 1'b0;
            trans_up_q    <= 1'b0;
            trans_dn_q    <= 1'b0;
            step_q        <= 1'b0;
        end else begin
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            state_q       <= state_d;
            db_cnt_q      <= db_cnt_d;
            rep_cnt_q     <= rep_cnt_d;
            rep_started_q <= rep_started_d;
            level_q       <= level_d;
            trans_up_q    <= trans_up_d;
            trans_dn_q    <= trans_dn_d;
            step_q        <= step_d;
        end
    end

    assign level    = level_q;
    assign trans_up = trans_up_q;
    assign trans_dn = trans_dn_q;
    assign step     = step_q;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Directed bench for button_conditioner. Two instances share the
//               input: one with auto-repeat (delay 20, period 8) and one with
//               auto-repeat disabled. A reference model built from the
//               behavioural rules (sliding window of synchronised samples,
//               count of steady held cycles) is compared every cycle, and
//               hand-computed pulse positions pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic CLK = 1'b0;
    logic RST_N;
    logic switch_input;
    logic level_a, trans_up_a, trans_dn_a, step_a;
    logic level_b, trans_up_b, trans_dn_b, step_b;

    button_conditioner #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) u_dut_a (
        .CLK(CLK), .RST_N(RST_N), .switch_input(switch_input),
        .level(level_a), .trans_up(trans_up_a), .trans_dn(trans_dn_a), .step(step_a)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(0), .REPEAT_PERIOD(RP)) u_dut_b (
        .CLK(CLK), .RST_N(RST_N), .switch_input(switch_input),
        .level(level_b), .trans_up(trans_up_b), .trans_dn(trans_dn_b), .step(step_b)
    );

    initial forever #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    initial forever begin
        @(posedge CLK);
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_s1 = 0, m_s2 = 0, m_prev = 0, m_lvl = 0;
    bit win[$];
    int m_h = 0;
    bit e_lvl = 0, e_up = 0, e_dn = 0, e_step_a = 0, e_step_b = 0;

    initial forever begin
        @(posedge CLK or negedge RST_N);
        if (!RST_N) begin
            m_s1 = 0; m_s2 = 0; m_prev = 0; m_lvl = 0; m_h = 0;
            win.delete();
            e_lvl = 0; e_up = 0; e_dn = 0; e_step_a = 0; e_step_b = 0;
        end else begin
            bit seen;
            bit all_opp;
            seen = m_s2;
            m_s2 = m_s1;
            m_s1 = switch_input;
            win.push_back(seen);
            if (win.size() > DB + 1) void'(win.pop_front());
            // a level change needs DB+1 consecutive synchronised samples of the other value
            all_opp = (win.size() == DB + 1);
            foreach (win[i]) if (win[i] == m_lvl) all_opp = 0;
            e_up = 0; e_dn = 0; e_step_a = 0; e_step_b = 0;
            if (all_opp) begin
                m_lvl = !m_lvl;
                if (m_lvl) begin
                    e_up = 1; e_step_a = 1; e_step_b = 1; m_h = 0;
                end else begin
                    e_dn = 1;
                end
            end else if (m_lvl && m_prev && seen) begin
                // one more steady held cycle
                m_h = m_h + 1;
                if (m_h >= RD && ((m_h - RD) % RP) == 0) e_step_a = 1;
            end
            m_prev = seen;
            e_lvl  = m_lvl;
        end
    end

    // ---------------- compare + pulse recorder ----------------
    int up_q[$], dn_q[$], stpa_q[$], stpb_q[$], rise_q[$], fall_q[$];
    logic prev_level = 1'b0;

    initial forever begin
        @(negedge CLK);
        chk("level_a",    int'(level_a),    int'(e_lvl));
        chk("trans_up_a", int'(trans_up_a), int'(e_up));
        chk("trans_dn_a", int'(trans_dn_a), int'(e_dn));
        chk("step_a",     int'(step_a),     int'(e_step_a));
        chk("level_b",    int'(level_b),    int'(e_lvl));
        chk("trans_up_b", int'(trans_up_b), int'(e_up));
        chk("trans_dn_b", int'(trans_dn_b), int'(e_dn));
        chk("step_b",     int'(step_b),     int'(e_step_b));
        if (trans_up_a === 1'b1) up_q.push_back(cyc);
        if (trans_dn_a === 1'b1) dn_q.push_back(cyc);
        if (step_a === 1'b1) stpa_q.push_back(cyc);
        if (step_b === 1'b1) stpb_q.push_back(cyc);
        if (level_a === 1'b1 && prev_level === 1'b0) rise_q.push_back(cyc);
        if (level_a === 1'b0 && prev_level === 1'b1) fall_q.push_back(cyc);
        prev_level = level_a;
    end

    task automatic clear_q();
        up_q.delete(); dn_q.delete(); stpa_q.delete();
        stpb_q.delete(); rise_q.delete(); fall_q.delete();
    endtask

    // set the input just after an edge; the next edge is the first to sample it
    task automatic hold(input logic v, input int n);
        switch_input = v;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    int e0, r0, m0, b0, z0;
    int offs[6] = '{0, 20, 28, 36, 44, 52};

    initial begin
        RST_N = 1'b0;
        switch_input = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_level",    int'(level_a),    0);
        chk("rst_trans_up", int'(trans_up_a), 0);
        chk("rst_trans_dn", int'(trans_dn_a), 0);
        chk("rst_step",     int'(step_a),     0);
        RST_N = 1'b1;
        hold(1'b0, 4);

        // clean press held long enough for auto-repeat
        clear_q();
        e0 = cyc + 1;
        hold(1'b1, 66);
        chk("press_up_count", up_q.size(), 1);
        chk("press_up_edge",  (up_q.size() > 0) ? up_q[0] : -1, e0 + 6);
        chk("press_rise_edge", (rise_q.size() > 0) ? rise_q[0] : -1, e0 + 6);
        chk("press_dn_count", dn_q.size(), 0);
        for (int i = 0; i < 6; i++)
            chk($sformatf("repeat_step_%0d", i), (stpa_q.size() > i) ? stpa_q[i] : -1, e0 + 6 + offs[i]);
        chk("norepeat_step_count", stpb_q.size(), 1);

        // release with a one-sample glitch back to pressed
        clear_q();
        r0 = cyc + 1;
        hold(1'b0, 3);
        hold(1'b1, 1);
        hold(1'b0, 12);
        chk("release_dn_count", dn_q.size(), 1);
        chk("release_dn_edge",  (dn_q.size() > 0) ? dn_q[0] : -1, r0 + 10);
        chk("release_fall_count", fall_q.size(), 1);
        chk("release_fall_edge", (fall_q.size() > 0) ? fall_q[0] : -1, r0 + 10);
        chk("release_up_count", up_q.size(), 0);

        // press one sample too short is rejected
        clear_q();
        m0 = cyc + 1;
        hold(1'b1, 4);
        hold(1'b0, 10);
        chk("short_up_count", up_q.size(), 0);
        chk("short_rise_count", rise_q.size(), 0);

        // press of exactly the minimum length is accepted
        clear_q();
        m0 = cyc + 1;
        hold(1'b1, 5);
        hold(1'b0, 12);
        chk("min_up_count", up_q.size(), 1);
        chk("min_up_edge", (up_q.size() > 0) ? up_q[0] : -1, m0 + 6);
        chk("min_dn_edge", (dn_q.size() > 0) ? dn_q[0] : -1, m0 + 11);

        // bouncy press
        clear_q();
        b0 = cyc + 1;
        hold(1'b1, 3);
        hold(1'b0, 1);
        hold(1'b1, 2);
        hold(1'b0, 2);
        hold(1'b1, 20);
        chk("bouncy_up_count", up_q.size(), 1);
        chk("bouncy_up_edge", (up_q.size() > 0) ? up_q[0] : -1, b0 + 14);
        chk("bouncy_rise_edge", (rise_q.size() > 0) ? rise_q[0] : -1, b0 + 14);

        // asynchronous reset in the middle of a hold
        #1;
        RST_N = 1'b0;
        #1;
        chk("async_level",    int'(level_a),    0);
        chk("async_trans_up", int'(trans_up_a), 0);
        chk("async_trans_dn", int'(trans_dn_a), 0);
        chk("async_step",     int'(step_a),     0);
        chk("async_level_b",  int'(level_b),    0);
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        clear_q();
        z0 = cyc + 1;
        hold(1'b1, 12);
        chk("rerelease_up_count", up_q.size(), 1);
        chk("rerelease_up_edge", (up_q.size() > 0) ? up_q[0] : -1, z0 + 6);

        hold(1'b0, 12);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
